serial_to_parallel_sr: RTL and testbench

Receive end of the serial adder datapath. Collects the LSB-first serial sum stream and the final carry from the bit-serial adder and assembles them into a WIDTH-bit parallel result. Presents the result to downstream logic with a valid/ready handshake. Mirror of the parallel-to-serial operand shifter: one bit is accepted per enabled clock.

---
 rtl/serial_adder_pkg.sv | 14 +
 rtl/sipo_bit_counter.sv | 27 ++
 rtl/serial_to_parallel_sr.sv | 126 ++++++++++++
 tb/tb_serial_to_parallel_sr.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder datapath: default word width,
// bit-counter width and the receive-side FSM encoding.
package serial_adder_pkg;

    localparam int DEFAULT_WIDTH = 8;
    localparam int CNT_W         = $clog2(DEFAULT_WIDTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        HOLD  = 2'd2
    } sipo_state_t;

endpackage

// File: rtl/sipo_bit_counter.sv
// Counts accepted serial bits of the current word; last flags the final bit.
module sipo_bit_counter
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int CW    = $clog2(WIDTH)
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          clear,
    input  logic          inc,
    output logic [CW-1:0] count,
    output logic          last
);

    always_ff @(posedge clk) begin
        if (!reset_n)
            count <= '0;
        else if (clear)
            count <= '0;
        else if (inc)
            count <= count + 1'b1;
    end

    assign last = (count == CW'(WIDTH - 1));

endmodule

// File: rtl/serial_to_parallel_sr.sv
// Receive end of the serial adder: assembles an LSB-first sum stream plus the
// final carry into a parallel word and offers it with a valid/ready handshake.
module serial_to_parallel_sr
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic             enable,
    input  logic             S_in,
    input  logic             C_in,
    output logic [WIDTH-1:0] sum_out,
    output logic             carry_out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy,
    output logic             overrun
);

    localparam int CW = $clog2(WIDTH);

    sipo_state_t      state_q, state_d;
    logic [WIDTH-1:0] shreg;
    logic [CW-1:0]    count;
    logic             last;

    logic cnt_clear, cnt_inc, sh_clr, sh_en, capture, valid_clr, ovr_set, ovr_clr;

    sipo_bit_counter #(.WIDTH(WIDTH), .CW(CW)) u_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (cnt_clear),
        .inc     (cnt_inc),
        .count   (count),
        .last    (last)
    );

    always_comb begin
        state_d   = state_q;
        cnt_clear = 1'b0;
        cnt_inc   = 1'b0;
        sh_clr    = 1'b0;
        sh_en     = 1'b0;
        capture   = 1'b0;
        valid_clr = 1'b0;
        ovr_set   = 1'b0;
        ovr_clr   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d   = SHIFT;
                    cnt_clear = 1'b1;
                    sh_clr    = 1'b1;
                    ovr_clr   = 1'b1;
                end
            end
            SHIFT: begin
                // start aborts the word and swallows any same-cycle enable
                if (start) begin
                    cnt_clear = 1'b1;
                    sh_clr    = 1'b1;
                    ovr_clr   = 1'b1;
                end else if (enable) begin
                    sh_en = 1'b1;
                    if (last) begin
                        capture   = 1'b1;
                        cnt_clear = 1'b1;
                        state_d   = HOLD;
                    end else begin
                        cnt_inc = 1'b1;
                    end
                end
            end
            HOLD: begin
                if (out_ready) begin
                    valid_clr = 1'b1;
                    if (start) begin
                        state_d   = SHIFT;
                        cnt_clear = 1'b1;
                        sh_clr    = 1'b1;
                        ovr_clr   = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
                // a fresh word's start takes precedence over flagging the stray bit
                if (enable && !ovr_clr)
                    ovr_set = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            shreg     <= '0;
            sum_out   <= '0;
            carry_out <= 1'b0;
            out_valid <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (sh_clr)
                shreg <= '0;
            else if (sh_en)
                shreg <= {S_in, shreg[WIDTH-1:1]};
            if (capture) begin
                sum_out   <= {S_in, shreg[WIDTH-1:1]};
                carry_out <= C_in;
                out_valid <= 1'b1;
            end else if (valid_clr) begin
                out_valid <= 1'b0;
            end
            if (ovr_clr)
                overrun <= 1'b0;
            else if (ovr_set)
                overrun <= 1'b1;
        end
    end

    assign busy = (state_q == SHIFT);

endmodule

// File: tb/tb_serial_to_parallel_sr.sv
// Directed bench for serial_to_parallel_sr (WIDTH=8) with hand-computed results.
module tb_serial_to_parallel_sr;

    logic       clk = 1'b0;
    logic       reset_n, start, enable, S_in, C_in, out_ready;
    logic [7:0] sum_out;
    logic       carry_out, out_valid, busy, overrun;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    serial_to_parallel_sr #(.WIDTH(8)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start),
        .enable    (enable),
        .S_in      (S_in),
        .C_in      (C_in),
        .sum_out   (sum_out),
        .carry_out (carry_out),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy),
        .overrun   (overrun)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // advance one edge; outputs sampled 1ns after the edge, inputs changed there too
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(input logic rdy);
        start = 1'b1; out_ready = rdy;
        tick();
        start = 1'b0; out_ready = 1'b0;
    endtask

    // feeds 8 bits LSB first; checks out_valid stays low until the last bit lands
    task automatic send_word(input logic [7:0] w, input logic c, input bit gaps);
        for (int i = 0; i < 8; i++) begin
            if (gaps) begin
                enable = 1'b0;
                S_in = 1'bx; C_in = 1'bx;
                repeat ($urandom_range(1, 3)) tick();
            end
            enable = 1'b1;
            S_in = w[i];
            C_in = (i == 7) ? c : 1'b0;
            if (i == 7) chk("valid_before_last", out_valid, 0);
            tick();
        end
        enable = 1'b0; S_in = 1'b0; C_in = 1'b0;
    endtask

    task automatic accept();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    initial begin
        reset_n = 1'b0; start = 1'b0; enable = 1'b0;
        S_in = 1'b0; C_in = 1'b0; out_ready = 1'b0;
        tick(); tick();
        chk("rst_sum", sum_out, 0);
        chk("rst_carry", carry_out, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ovr", overrun, 0);
        reset_n = 1'b1;

        // enables in IDLE must be ignored
        enable = 1'b1; S_in = 1'b1; tick(); tick(); enable = 1'b0;
        chk("idle_busy", busy, 0);
        chk("idle_valid", out_valid, 0);

        // word A5, carry 1
        pulse_start(1'b0);
        chk("a5_busy", busy, 1);
        send_word(8'hA5, 1'b1, 1'b0);
        chk("a5_valid", out_valid, 1);
        chk("a5_sum", sum_out, 8'hA5);
        chk("a5_carry", carry_out, 1);
        chk("a5_busy_hold", busy, 0);
        accept();
        chk("a5_valid_clr", out_valid, 0);
        chk("a5_busy_idle", busy, 0);
        chk("a5_sum_retain", sum_out, 8'hA5);

        // word 3C with gaps, downstream stalls 5 cycles
        pulse_start(1'b0);
        send_word(8'h3C, 1'b0, 1'b1);
        for (int k = 0; k < 5; k++) begin
            chk("3c_valid_stall", out_valid, 1);
            chk("3c_sum_stall", sum_out, 8'h3C);
            tick();
        end
        // start without ready must not drop the result
        pulse_start(1'b0);
        chk("3c_start_ign_valid", out_valid, 1);
        chk("3c_start_ign_busy", busy, 0);
        chk("3c_carry", carry_out, 0);
        accept();
        chk("3c_accepted", out_valid, 0);

        // back-to-back FF/0 then 01/1
        pulse_start(1'b0);
        send_word(8'hFF, 1'b0, 1'b0);
        chk("ff_sum", sum_out, 8'hFF);
        chk("ff_carry", carry_out, 0);
        pulse_start(1'b1);
        chk("b2b_valid", out_valid, 0);
        chk("b2b_busy", busy, 1);
        send_word(8'h01, 1'b1, 1'b0);
        chk("01_sum", sum_out, 8'h01);
        chk("01_carry", carry_out, 1);
        chk("01_valid", out_valid, 1);
        accept();

        // abort after 4 ones; abort cycle also carries an enable that must be dropped
        pulse_start(1'b0);
        enable = 1'b1; S_in = 1'b1;
        repeat (4) tick();
        start = 1'b1;
        tick();
        start = 1'b0; enable = 1'b0;
        chk("abort_busy", busy, 1);
        send_word(8'h5A, 1'b0, 1'b0);
        chk("5a_sum", sum_out, 8'h5A);
        chk("5a_valid", out_valid, 1);
        accept();

        // overrun
        pulse_start(1'b0);
        send_word(8'h12, 1'b0, 1'b0);
        chk("12_ovr_pre", overrun, 0);
        enable = 1'b1; S_in = 1'b1; tick();
        enable = 1'b0; tick();
        enable = 1'b1; S_in = 1'b1; tick();
        enable = 1'b0;
        chk("ovr_set", overrun, 1);
        chk("ovr_sum", sum_out, 8'h12);
        chk("ovr_valid", out_valid, 1);
        accept();
        chk("ovr_sticky", overrun, 1);
        pulse_start(1'b0);
        chk("ovr_clr_start", overrun, 0);

        // reset mid-word after 5 bits
        enable = 1'b1; S_in = 1'b1;
        repeat (5) tick();
        enable = 1'b0;
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        chk("mrst_sum", sum_out, 0);
        chk("mrst_carry", carry_out, 0);
        chk("mrst_valid", out_valid, 0);
        chk("mrst_busy", busy, 0);
        chk("mrst_ovr", overrun, 0);
        pulse_start(1'b0);
        send_word(8'h96, 1'b1, 1'b0);
        chk("96_sum", sum_out, 8'h96);
        chk("96_carry", carry_out, 1);
        chk("96_valid", out_valid, 1);
        accept();
        chk("96_done", out_valid, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
